lcd_rgb_scanout: RTL and testbench
==================================

// Module: lcd_rgb_scanout
// PURPOSE
// - Downstream of the 8080 receiver's pixel FIFO. Generates RGB panel timing (HSYNC/VSYNC/DE/PCLK),
//   pops RGB565 pixels from the FIFO (high byte first) and drives the panel bus.
// - HSYNC/VSYNC are also returned to the 8080 controller for frame alignment.
// - One pixel slot = 2 CLK cycles; LCD_PCLK = CLK/2.
// PARAMETERS
// H_ACTIVE 480  visible pixels per line
// H_FP 8  H_SYNC 4  H_BP 43     horizontal front porch / sync / back porch, in pixels
// V_ACTIVE 272  visible lines per frame
// V_FP 4  V_SYNC 4  V_BP 12     vertical front porch / sync / back porch, in lines
// SYNC_POL 0    sync active level (0 = active-low)
// LVL_W 10      width of fifo_level
// UF_COLOR 16'hF800  RGB565 colour shown on underflow
// PORTS
// CLK         in   1      system clock, 2x pixel clock
// nRST        in   1      asynchronous active-low reset
// EN          in   1      scan enable
// fifo_level  in   LVL_W  bytes held in the pixel FIFO
// fifo_data   in   8      FIFO head byte, first-word-fall-through
// fifo_rd     out  1      pop one byte this CLK
// HSYNC       out  1      horizontal sync, also fed back to the 8080 controller
// VSYNC       out  1      vertical sync, also fed back to the 8080 controller
// LCD_PCLK    out  1      panel pixel clock
// LCD_DE      out  1      data enable
// LCD_R/G/B   out  5/6/5  pixel colour
// frame_start out  1      1-CLK pulse at h=0, v=0, phase 0
// underflow   out  1      sticky; set on any underflow slot
// uf_clr      in   1      clears underflow; a set in the same CLK wins
// BEHAVIOUR
// - Reset values: all counters = 0; phase = 0; fifo_rd = 0; DE = 0; RGB = 0; frame_start = 0; underflow = 0;
//   LCD_PCLK = 0; HSYNC/VSYNC = ~SYNC_POL (inactive).
// - phase toggles every CLK. LCD_PCLK = registered phase.
// - hcnt runs 0..H_TOTAL-1 and advances when phase = 1; H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP.
//   At wrap, hcnt returns to 0 and vcnt advances. vcnt runs 0..V_TOTAL-1 and wraps to 0.
// - Region order, horizontal and vertical: SYNC [0, SYNC) -> BP -> ACTIVE -> FP.
// - Active slot: hcnt and vcnt are both in ACTIVE.
// - Slot FSM: IDLE -> HI -> LO -> IDLE.
//   - At phase 0 of an active slot: if fifo_level >= 2, go to HI: fifo_rd = 1, latch fifo_data into pix[15:8].
//   - Else this is an underflow slot: no reads in either cycle, underflow is set, and the pixel is UF_COLOR.
//   - In LO (phase 1): fifo_rd = 1 and pix[7:0] is latched. A FIFO going empty between HI and LO
//     cannot happen, because level >= 2 was checked.
// - fifo_rd is never asserted outside active slots, and at most 2 pops per slot. Byte alignment is therefore
//   preserved across underflows.
// - Output latency: syncs, DE and RGB for counter position (h,v) are registered together and appear at the
//   phase-0 edge of the following slot (2 CLK after the slot starts). Sync and data remain mutually aligned.
// - RGB = {pix[15:11], pix[10:5], pix[4:0]} when DE = 1, and 0 when DE = 0.
// - HSYNC = SYNC_POL while hcnt is in H SYNC. VSYNC = SYNC_POL while vcnt is in V SYNC, changing at hcnt = 0.
// - EN = 0:
//   - an in-progress frame completes to its final FP line, then counters hold at 0 with phase 0;
//   - in the held state, syncs are inactive, DE = 0 and no reads occur.
//   - EN rising restarts scan at the next CLK with frame_start.
// - Async reset mid-frame: immediate return to reset values. A pixel whose high byte was popped but whose low
//   byte was not leaves the FIFO misaligned. The FIFO is reset by the same nRST.
// - underflow: set wins over uf_clr in the same CLK.
// TESTING
// - Small params (H 4/1/1/1, V 3/1/1/1), FIFO pre-filled with 24 bytes -> every frame is 7x6 slots;
//   12 pixels are output with DE; 24 pops total; HSYNC period 14 CLK.
// - Bytes AB,CD -> first DE pixel R=0x15 G=0x1E B=0x0D; DE aligned with the first active slot, delayed 2 CLK.
// - fifo_level = 1 during an active slot -> 0 pops that slot; RGB = UF_COLOR; underflow = 1;
//   next slot at level 3 reads 2 bytes and shows correct data.
// - uf_clr in the same CLK as a new underflow -> underflow stays 1; uf_clr alone -> 0 next CLK.
// - EN = 0 mid-frame -> frame completes then holds (no frame_start, syncs inactive);
//   EN = 1 -> frame_start next CLK.
// - nRST low during an active slot -> all outputs take reset values asynchronously;
//   after release, frame_start occurs on the first CLK.

Source files
------------

// File: rtl/lcd_rgb_scanout_if.sv
// Pixel FIFO read port plus RGB panel bus between the scanout engine and its neighbours.
// The master side is the scanout engine; the slave side is the FIFO and the panel.
interface lcd_rgb_scanout_if #(
  parameter int LVL_W = 10
);
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       fifo_data;
  logic             fifo_rd;
  logic             HSYNC;
  logic             VSYNC;
  logic             LCD_PCLK;
  logic             LCD_DE;
  logic [4:0]       LCD_R;
  logic [5:0]       LCD_G;
  logic [4:0]       LCD_B;

  modport master (
    input  fifo_level, fifo_data,
    output fifo_rd, HSYNC, VSYNC, LCD_PCLK, LCD_DE, LCD_R, LCD_G, LCD_B
  );

  modport slave (
    output fifo_level, fifo_data,
    input  fifo_rd, HSYNC, VSYNC, LCD_PCLK, LCD_DE, LCD_R, LCD_G, LCD_B
  );
endinterface

// File: rtl/lcd_rgb_scanout.sv
// RGB panel timing generator; pops RGB565 pixels (high byte first) from a FWFT byte FIFO.
// Slot FSM states:
//   state   | meaning
//   ST_IDLE | no pixel in flight; phase-0 cycle of an active slot decides pop or underflow
//   ST_HI   | high byte captured, low byte being popped this (phase-1) cycle
//   ST_LO   | pixel just completed; behaves as IDLE so back-to-back slots start at once
module lcd_rgb_scanout #(
  parameter int          H_ACTIVE = 480,
  parameter int          H_FP     = 8,
  parameter int          H_SYNC   = 4,
  parameter int          H_BP     = 43,
  parameter int          V_ACTIVE = 272,
  parameter int          V_FP     = 4,
  parameter int          V_SYNC   = 4,
  parameter int          V_BP     = 12,
  parameter logic        SYNC_POL = 1'b0,
  parameter int          LVL_W    = 10,
  parameter logic [15:0] UF_COLOR = 16'hF800
) (
  input  logic CLK,
  input  logic nRST,
  input  logic EN,
  input  logic uf_clr,
  output logic frame_start,
  output logic underflow,
  lcd_rgb_scanout_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [LVL_W-1:0] LVL_PIXEL = LVL_W'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_HI, ST_LO} slot_st_t;

  slot_st_t       st, st_nxt;
  logic           phase;
  logic [HW-1:0]  hcnt;
  logic [VW-1:0]  vcnt;
  logic [7:0]     pix_hi;
  logic           de_q, hs_q, vs_q;
  logic [15:0]    rgb_q;
  logic           origin, run, act;
  logic           rd_c, ld_hi, uf_set;

  assign origin = ~phase && (hcnt == '0) && (vcnt == '0);
  // With EN low the scan only stops once the frame has wrapped back to the origin.
  assign run    = EN | ~origin;
  assign act    = (hcnt >= H_ACT_BEG) && (hcnt < H_ACT_END) &&
                  (vcnt >= V_ACT_BEG) && (vcnt < V_ACT_END);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      phase       <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= EN & origin;
      if (run) begin
        phase <= ~phase;
        if (phase) begin
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = ST_IDLE;
    rd_c   = 1'b0;
    ld_hi  = 1'b0;
    uf_set = 1'b0;
    case (st)
      ST_IDLE, ST_LO: begin
        if (~phase && act) begin
          // Both bytes must already be present, so a pixel is never split across slots.
          if (bus.fifo_level >= LVL_PIXEL) begin
            rd_c   = 1'b1;
            ld_hi  = 1'b1;
            st_nxt = ST_HI;
          end else begin
            uf_set = 1'b1;
          end
        end
      end
      ST_HI: begin
        rd_c   = 1'b1;
        st_nxt = ST_LO;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pix_hi    <= 8'h00;
      underflow <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      rgb_q     <= 16'h0000;
    end else begin
      if (ld_hi) pix_hi <= bus.fifo_data;
      underflow <= uf_set | (underflow & ~uf_clr);
      // Sync, DE and colour for the current slot are registered together at its end.
      if (phase) begin
        de_q  <= act;
        hs_q  <= (hcnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vs_q  <= (vcnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        if (!act)             rgb_q <= 16'h0000;
        else if (st == ST_HI) rgb_q <= {pix_hi, bus.fifo_data};
        else                  rgb_q <= UF_COLOR;
      end
    end
  end

  assign bus.fifo_rd  = rd_c;
  assign bus.HSYNC    = hs_q;
  assign bus.VSYNC    = vs_q;
  assign bus.LCD_PCLK = phase;
  assign bus.LCD_DE   = de_q;
  assign bus.LCD_R    = rgb_q[15:11];
  assign bus.LCD_G    = rgb_q[10:5];
  assign bus.LCD_B    = rgb_q[4:0];

endmodule

// File: tb/tb_lcd_rgb_scanout.sv
// Directed bench for lcd_rgb_scanout on a 7x6-slot frame with a byte-queue FIFO model.
module tb_lcd_rgb_scanout;

  logic CLK;
  logic nRST;
  logic EN;
  logic uf_clr;
  logic frame_start;
  logic underflow;

  lcd_rgb_scanout_if #(.LVL_W(10)) bus ();

  lcd_rgb_scanout #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .LVL_W(10), .UF_COLOR(16'hF800)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .EN(EN),
    .uf_clr(uf_clr),
    .frame_start(frame_start),
    .underflow(underflow),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int        checks = 0;
  int        errors = 0;
  int        tcount = 0;
  int        total_pops = 0;
  int        lvl_force = -1;
  logic [7:0] q[$];

  function automatic logic [7:0] exp_byte(input int i);
    if (i == 0) return 8'hAB;
    if (i == 1) return 8'hCD;
    return 8'((i * 37 + 5) & 255);
  endfunction

  function automatic logic [15:0] rgb_now();
    return {bus.LCD_R, bus.LCD_G, bus.LCD_B};
  endfunction

  task automatic drive_fifo();
    bus.fifo_level = (lvl_force >= 0) ? 10'(lvl_force) : 10'(q.size());
    bus.fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) q.push_back(exp_byte(i));
    drive_fifo();
  endtask

  // One CLK: sample the pop request mid-cycle, then update the FIFO model just after the edge.
  task automatic tick();
    logic rd_seen;
    @(negedge CLK);
    rd_seen = bus.fifo_rd;
    if (rd_seen) total_pops++;
    @(posedge CLK);
    #1;
    if (rd_seen && nRST && q.size() > 0) void'(q.pop_front());
    tcount++;
    drive_fifo();
  endtask

  task automatic reset_dut();
    nRST = 1'b0;
    uf_clr = 1'b0;
    lvl_force = -1;
    q.delete();
    total_pops = 0;
    drive_fifo();
    tick();
    tick();
    nRST = 1'b1;
    tcount = 0;
  endtask

  task automatic test_reset();
    EN = 1'b1;
    uf_clr = 1'b0;
    drive_fifo();
    #2 nRST = 1'b0;
    tick();
    tick();
    checks++; if (bus.HSYNC !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", bus.HSYNC); end
    checks++; if (bus.VSYNC !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", bus.VSYNC); end
    checks++; if (bus.LCD_DE !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", bus.LCD_DE); end
    checks++; if (rgb_now() !== 16'h0000) begin errors++; $display("FAIL reset_rgb: got %h expected 0000", rgb_now()); end
    checks++; if (bus.LCD_PCLK !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b expected 0", bus.LCD_PCLK); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", bus.fifo_rd); end
    nRST = 1'b1;
  endtask

  task automatic test_frame();
    logic [15:0] pix[16];
    int   npix = 0;
    int   nfall = 0;
    int   fall[2];
    int   fs_extra = 0;
    logic prev_hs, de33, de34, vs15, vs16, fs85;
    logic [15:0] expw;
    reset_dut();
    fill(24);
    EN = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_first: got %b expected 1", frame_start); end
    tick();
    checks++; if (bus.HSYNC !== 1'b0 || bus.VSYNC !== 1'b0) begin errors++; $display("FAIL first_sync: got hs=%b vs=%b expected 0 0", bus.HSYNC, bus.VSYNC); end
    prev_hs = bus.HSYNC;
    fall[0] = 0; fall[1] = 0;
    de33 = 1'bx; de34 = 1'bx; vs15 = 1'bx; vs16 = 1'bx; fs85 = 1'bx;
    while (tcount < 86) begin
      tick();
      if (bus.LCD_DE && !bus.LCD_PCLK) begin
        if (npix < 16) pix[npix] = rgb_now();
        npix++;
      end
      if (prev_hs && !bus.HSYNC && nfall < 2) begin fall[nfall] = tcount; nfall++; end
      prev_hs = bus.HSYNC;
      if (frame_start && tcount <= 84) fs_extra++;
      if (tcount == 15) vs15 = bus.VSYNC;
      if (tcount == 16) vs16 = bus.VSYNC;
      if (tcount == 33) de33 = bus.LCD_DE;
      if (tcount == 34) de34 = bus.LCD_DE;
      if (tcount == 85) fs85 = frame_start;
    end
    checks++; if (npix !== 12) begin errors++; $display("FAIL pixel_count: got %0d expected 12", npix); end
    checks++; if (total_pops !== 24) begin errors++; $display("FAIL pop_count: got %0d expected 24", total_pops); end
    checks++; if (pix[0][15:11] !== 5'h15 || pix[0][10:5] !== 6'h1E || pix[0][4:0] !== 5'h0D)
      begin errors++; $display("FAIL first_pixel: got %h expected R15 G1E B0D", pix[0]); end
    for (int k = 1; k < 12 && k < npix; k++) begin
      expw = {exp_byte(2 * k), exp_byte(2 * k + 1)};
      checks++; if (pix[k] !== expw) begin errors++; $display("FAIL pixel_%0d: got %h expected %h", k, pix[k], expw); end
    end
    checks++; if (de33 !== 1'b0 || de34 !== 1'b1) begin errors++; $display("FAIL de_align: got de33=%b de34=%b expected 0 1", de33, de34); end
    checks++; if (fall[0] !== 16 || fall[1] - fall[0] !== 14) begin errors++; $display("FAIL hsync_period: got falls %0d %0d expected 16 30", fall[0], fall[1]); end
    checks++; if (vs15 !== 1'b0 || vs16 !== 1'b1) begin errors++; $display("FAIL vsync_end: got vs15=%b vs16=%b expected 0 1", vs15, vs16); end
    checks++; if (fs_extra !== 0) begin errors++; $display("FAIL frame_start_spurious: got %0d pulses expected 0", fs_extra); end
    checks++; if (fs85 !== 1'b1) begin errors++; $display("FAIL frame_start_wrap: got %b expected 1", fs85); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL no_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_underflow();
    int p0;
    reset_dut();
    q.push_back(8'h12); q.push_back(8'h34); q.push_back(8'h56);
    drive_fifo();
    EN = 1'b1;
    while (tcount < 32) tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %b expected 0", underflow); end
    lvl_force = 1;
    drive_fifo();
    p0 = total_pops;
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
    lvl_force = -1;
    drive_fifo();
    tick();
    checks++; if (total_pops - p0 !== 0) begin errors++; $display("FAIL uf_no_pops: got %0d expected 0", total_pops - p0); end
    checks++; if (bus.LCD_DE !== 1'b1 || rgb_now() !== 16'hF800) begin errors++; $display("FAIL uf_color: got de=%b rgb=%h expected 1 f800", bus.LCD_DE, rgb_now()); end
    tick();
    tick();
    checks++; if (total_pops - p0 !== 2) begin errors++; $display("FAIL uf_recover_pops: got %0d expected 2", total_pops - p0); end
    checks++; if (rgb_now() !== 16'h1234) begin errors++; $display("FAIL uf_recover_data: got %h expected 1234", rgb_now()); end
  endtask

  task automatic test_uf_clr();
    int p0;
    p0 = total_pops;
    uf_clr = 1'b1;
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_clr_set_wins: got %b expected 1", underflow); end
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clr_alone: got %b expected 0", underflow); end
    checks++; if (rgb_now() !== 16'hF800) begin errors++; $display("FAIL uf_color_2: got %h expected f800", rgb_now()); end
    uf_clr = 1'b0;
    tick();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_reset_again: got %b expected 1", underflow); end
    while (tcount < 84) tick();
    checks++; if (total_pops - p0 !== 0) begin errors++; $display("FAIL uf_single_byte_kept: got %0d pops expected 0", total_pops - p0); end
  endtask

  task automatic test_en_hold();
    int   fs_cnt = 0;
    int   hold_bad = 0;
    logic hs72;
    reset_dut();
    EN = 1'b1;
    while (tcount < 20) tick();
    EN = 1'b0;
    hs72 = 1'bx;
    while (tcount < 100) begin
      tick();
      if (frame_start) fs_cnt++;
      if (tcount == 72) hs72 = bus.HSYNC;
      if (tcount >= 85 && (bus.HSYNC !== 1'b1 || bus.VSYNC !== 1'b1 || bus.LCD_DE !== 1'b0 ||
                           bus.LCD_PCLK !== 1'b0 || bus.fifo_rd !== 1'b0)) hold_bad++;
    end
    checks++; if (hs72 !== 1'b0) begin errors++; $display("FAIL en_frame_completes: got hs72=%b expected 0", hs72); end
    checks++; if (fs_cnt !== 0) begin errors++; $display("FAIL en_no_frame_start: got %0d expected 0", fs_cnt); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL en_hold_idle: got %0d bad cycles expected 0", hold_bad); end
    EN = 1'b1;
    tick();
    checks++; if (frame_start !== 1'b1 || bus.LCD_PCLK !== 1'b1) begin errors++; $display("FAIL en_restart: got fs=%b pclk=%b expected 1 1", frame_start, bus.LCD_PCLK); end
    tick();
    checks++; if (bus.HSYNC !== 1'b0) begin errors++; $display("FAIL en_restart_sync: got %b expected 0", bus.HSYNC); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    fill(24);
    EN = 1'b1;
    while (tcount < 35) tick();
    checks++; if (bus.LCD_DE !== 1'b1 || bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL mid_precond: got de=%b rd=%b expected 1 1", bus.LCD_DE, bus.fifo_rd); end
    #2 nRST = 1'b0;
    #1;
    checks++; if (bus.fifo_rd !== 1'b0 || bus.LCD_DE !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_de: got rd=%b de=%b expected 0 0", bus.fifo_rd, bus.LCD_DE); end
    checks++; if (rgb_now() !== 16'h0000 || bus.LCD_PCLK !== 1'b0) begin errors++; $display("FAIL mid_rst_rgb_pclk: got rgb=%h pclk=%b expected 0000 0", rgb_now(), bus.LCD_PCLK); end
    checks++; if (bus.HSYNC !== 1'b1 || bus.VSYNC !== 1'b1) begin errors++; $display("FAIL mid_rst_sync: got hs=%b vs=%b expected 1 1", bus.HSYNC, bus.VSYNC); end
    q.delete();
    total_pops = 0;
    fill(24);
    tick();
    tick();
    nRST = 1'b1;
    tcount = 0;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_rst_frame_start: got %b expected 1", frame_start); end
    while (tcount < 34) tick();
    checks++; if (rgb_now() !== 16'hABCD) begin errors++; $display("FAIL mid_rst_first_pixel: got %h expected abcd", rgb_now()); end
  endtask

  initial begin
    nRST = 1'b1;
    EN = 1'b1;
    uf_clr = 1'b0;
    test_reset();
    test_frame();
    test_underflow();
    test_uf_clr();
    test_en_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
